// File: rtl/leaf_bridge_pkg.sv
// Shared types and helpers for the leaf stream bridge: run-control FSM states and
// the FIFO pointer-width helper used by every channel buffer.
package leaf_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bridge_state_t;

    localparam int CNT_BITS = 32;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic int fifo_ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Per-channel first-word-fall-through FIFO with a registered producer-side ack,
// so there is no combinational path from the consumer ack back to the producer.
module bridge_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    input  logic                    in_vld,
    output logic                    in_ack,
    output logic [PAYLOAD_BITS-1:0] out_data,
    output logic                    out_vld,
    input  logic                    out_ack
);

    localparam int PW = fifo_ptr_bits(FIFO_DEPTH);
    localparam int AW = PW - 1;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr_nxt;
    logic [PW-1:0]           rd_ptr_nxt;
    logic                    empty;
    logic                    full_nxt;
    logic                    push;
    logic                    pop;
    logic                    in_ready;

    assign empty      = (wr_ptr == rd_ptr);
    assign push       = in_vld && in_ready;
    assign pop        = !empty && out_ack;
    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);
    assign full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    // Ready is held low through reset and rises on the first edge after release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            in_ready <= !full_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    assign in_ack   = in_ready;
    assign out_vld  = !empty;
    assign out_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/leaf_stream_bridge.sv
// Leaf-interface <-> kernel stream bridge: one FIFO per channel plus run-control FSM.
// Define LEAF_BRIDGE_WORD_CNT_EN to add per-channel transferred-word counters (in_cnt, out_cnt).
module leaf_stream_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int PAYLOAD_BITS  = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_V_V,
    output logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_vld,
    input  logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_V_V,
    input  logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_vld,
    output logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic                                  ap_start,
    output logic                                  kernel_ap_start,
    input  logic                                  kernel_ap_done,
    output logic                                  done,
    output logic                                  busy
`ifdef LEAF_BRIDGE_WORD_CNT_EN
    ,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]      in_cnt,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_cnt
`endif
);

    bridge_state_t state;
    bridge_state_t state_nxt;
    logic          out_all_empty;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        bridge_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_data  (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .in_vld   (vld_interface2user[i]),
            .in_ack   (ack_user2interface[i]),
            .out_data (Input_V_V[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .out_vld  (Input_V_V_ap_vld[i]),
            .out_ack  (Input_V_V_ap_ack[i])
        );
    end

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
        bridge_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_data  (Output_V_V[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .in_vld   (Output_V_V_ap_vld[i]),
            .in_ack   (Output_V_V_ap_ack[i]),
            .out_data (din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .out_vld  (vld_user2interface[i]),
            .out_ack  (ack_interface2user[i])
        );
    end

    // An output FIFO presents valid exactly when it holds a word.
    assign out_all_empty = ~|vld_user2interface;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt       = state;
        kernel_ap_start = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ap_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                kernel_ap_start = 1'b1;
                busy            = 1'b1;
                if (kernel_ap_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (out_all_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef LEAF_BRIDGE_WORD_CNT_EN
    logic run_entry;
    assign run_entry = (state == ST_IDLE) && ap_start;

    // A transfer in the run-entry cycle counts as the first word of the new run.
    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_cnt
        logic [CNT_BITS-1:0] cnt;
        logic                xfer;
        assign xfer = Input_V_V_ap_vld[i] && Input_V_V_ap_ack[i];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)       cnt <= '0;
            else if (run_entry) cnt <= CNT_BITS'(xfer);
            else if (xfer)      cnt <= cnt + 1'b1;
        end
        assign in_cnt[i*CNT_BITS +: CNT_BITS] = cnt;
    end

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out_cnt
        logic [CNT_BITS-1:0] cnt;
        logic                xfer;
        assign xfer = vld_user2interface[i] && ack_interface2user[i];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)       cnt <= '0;
            else if (run_entry) cnt <= CNT_BITS'(xfer);
            else if (xfer)      cnt <= cnt + 1'b1;
        end
        assign out_cnt[i*CNT_BITS +: CNT_BITS] = cnt;
    end
`endif

endmodule
